// File: rtl/maxpool2x2.sv
// Streaming 2x2 stride-2 max pooling over a raster pixel stream.
// One half-row line buffer; floor behaviour for odd map sizes.
module maxpool2x2 #(
    parameter int N          = 16,
    parameter int CHANNEL    = 3,
    parameter int INPUT_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 input_vld,
    input  logic [CHANNEL*N-1:0] input_din,
    output logic [CHANNEL*N-1:0] pool_dout,
    output logic                 pool_dout_vld,
    output logic                 pool_dout_end
);

    localparam int OUTPUT_SIZE = INPUT_SIZE / 2;
    localparam int CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int LW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PW = CHANNEL * N;
    localparam logic [CW-1:0] COL_LAST  = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] POOL_LAST = CW'(2 * OUTPUT_SIZE - 1);

    function automatic logic [PW-1:0] pix_max(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b
    );
        logic [PW-1:0] m;
        m = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            if ($signed(a[c*N +: N]) > $signed(b[c*N +: N]))
                m[c*N +: N] = a[c*N +: N];
            else
                m[c*N +: N] = b[c*N +: N];
        end
        return m;
    endfunction

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [PW-1:0] hold;
    logic [PW-1:0] linebuf [OUTPUT_SIZE];
    logic [PW-1:0] hmax;
    logic [PW-1:0] pool_max;
    logic [LW-1:0] lb_idx;
    logic          last_col;
    logic          last_row;

    always_comb begin
        last_col = (col == COL_LAST);
        last_row = (row == COL_LAST);
        lb_idx   = LW'(col >> 1);
        hmax     = pix_max(hold, input_din);
        pool_max = pix_max(linebuf[lb_idx], hmax);
    end

    // Raster position; wraps on the true last pixel even in floor mode.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col <= '0;
            row <= '0;
        end else if (input_vld) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            hold <= '0;
        else if (input_vld && !col[0])
            hold <= input_din;
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (input_vld && col[0] && !row[0])
            linebuf[lb_idx] <= hmax;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pool_dout     <= '0;
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
        end else begin
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b0;
            if (input_vld && col[0] && row[0]) begin
                pool_dout     <= pool_max;
                pool_dout_vld <= 1'b1;
                pool_dout_end <= (row == POOL_LAST) && (col == POOL_LAST);
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
// Randomised bench for maxpool2x2: three instances (4x4/1ch, 2x2/3ch,
// 5x5/2ch) checked every cycle against a window-max frame model.
module tb_maxpool2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vld_a, vld_b, vld_c;
    logic [15:0] din_a;
    logic [47:0] din_b;
    logic [31:0] din_c;
    logic [15:0] dout_a;
    logic [47:0] dout_b;
    logic [31:0] dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        de_a, de_b, de_c;

    maxpool2x2 #(.N(16), .CHANNEL(1), .INPUT_SIZE(4)) u_a (
        .clk(clk), .rst_n(rst_n), .input_vld(vld_a), .input_din(din_a),
        .pool_dout(dout_a), .pool_dout_vld(dv_a), .pool_dout_end(de_a)
    );
    maxpool2x2 #(.N(16), .CHANNEL(3), .INPUT_SIZE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .input_vld(vld_b), .input_din(din_b),
        .pool_dout(dout_b), .pool_dout_vld(dv_b), .pool_dout_end(de_b)
    );
    maxpool2x2 #(.N(16), .CHANNEL(2), .INPUT_SIZE(5)) u_c (
        .clk(clk), .rst_n(rst_n), .input_vld(vld_c), .input_din(din_c),
        .pool_dout(dout_c), .pool_dout_vld(dv_c), .pool_dout_end(de_c)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [47:0] exp_dout  [3];
    logic        exp_vld   [3];
    logic        exp_end   [3];
    logic [47:0] pend_dout [3];
    logic        pend_vld  [3];
    logic        pend_end  [3];
    logic [47:0] pix [0:24];

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [47:0] lane_max(input logic [47:0] a,
                                             input logic [47:0] b);
        logic [47:0] m;
        for (int l = 0; l < 3; l++) begin
            if ($signed(a[l*16 +: 16]) >= $signed(b[l*16 +: 16]))
                m[l*16 +: 16] = a[l*16 +: 16];
            else
                m[l*16 +: 16] = b[l*16 +: 16];
        end
        return m;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [47:0] data);
        case (d)
            0: begin vld_a = v; din_a = data[15:0]; end
            1: begin vld_b = v; din_b = data; end
            default: begin vld_c = v; din_c = data[31:0]; end
        endcase
    endtask

    // One clock edge; afterwards the expectation for the next cycle is set.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (rst_n) begin
                exp_vld[d]  = 1'b0;
                exp_end[d]  = 1'b0;
                exp_dout[d] = '0;
            end else begin
                exp_vld[d] = pend_vld[d];
                exp_end[d] = pend_end[d];
                if (pend_vld[d]) exp_dout[d] = pend_dout[d];
            end
            pend_vld[d] = 1'b0;
            pend_end[d] = 1'b0;
        end
    endtask

    // mode 0: ramp + off, 1: random lanes, 2: fixed signed 2x2 table
    task automatic run_frame(input int d, input int sz, input int mode,
                             input int off, input int gap, input int npix);
        int ch, os, cnt, r, c;
        logic [47:0] p, w;
        logic [47:0] tab [4];
        tab[0] = {16'hFFFB, 16'h7FFF, 16'hFFFD};
        tab[1] = {16'hFFFB, 16'h8000, 16'hFFFF};
        tab[2] = {16'hFFFB, 16'h0000, 16'hFFF9};
        tab[3] = {16'hFFFB, 16'h0001, 16'hFFFE};
        ch  = (d == 1) ? 3 : (d == 2) ? 2 : 1;
        os  = sz / 2;
        cnt = (npix < 0) ? sz * sz : npix;
        for (int i = 0; i < sz * sz; i++) begin
            p = '0;
            if (mode == 0)
                p = 48'(i + off);
            else if (mode == 1)
                for (int l = 0; l < ch; l++) p[l*16 +: 16] = 16'($urandom);
            else
                p = tab[i % 4];
            pix[i] = p;
        end
        for (int i = 0; i < cnt; i++) begin
            r = i / sz;
            c = i % sz;
            while ($urandom_range(99) < gap) begin
                set_in(d, 1'b0, '0);
                tick();
            end
            set_in(d, 1'b1, pix[i]);
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * os && c < 2 * os) begin
                w = lane_max(lane_max(pix[i-sz-1], pix[i-sz]),
                             lane_max(pix[i-1], pix[i]));
                pend_vld[d]  = 1'b1;
                pend_dout[d] = w;
                pend_end[d]  = (r == 2 * os - 1) && (c == 2 * os - 1);
            end
            tick();
        end
        set_in(d, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("a_vld", 48'(dv_a), 48'(exp_vld[0]));
            check("a_end", 48'(de_a), 48'(exp_end[0]));
            check("a_dout", 48'(dout_a), exp_dout[0]);
            check("b_vld", 48'(dv_b), 48'(exp_vld[1]));
            check("b_end", 48'(de_b), 48'(exp_end[1]));
            check("b_dout", dout_b, exp_dout[1]);
            check("c_vld", 48'(dv_c), 48'(exp_vld[2]));
            check("c_end", 48'(de_c), 48'(exp_end[2]));
            check("c_dout", 48'(dout_c), exp_dout[2]);
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            pend_vld[d]  = 1'b0;
            pend_end[d]  = 1'b0;
            pend_dout[d] = '0;
            exp_vld[d]   = 1'b0;
            exp_end[d]   = 1'b0;
            exp_dout[d]  = '0;
            set_in(d, 1'b0, '0);
        end
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();

        run_frame(0, 4, 0, 0, 0, -1);
        tick();
        run_frame(1, 2, 2, 0, 0, -1);
        tick();
        run_frame(0, 4, 0, 0, 50, -1);
        tick();
        run_frame(2, 5, 0, 0, 0, -1);
        run_frame(2, 5, 0, 0, 0, -1);
        tick();
        run_frame(0, 4, 0, 0, 0, -1);
        run_frame(0, 4, 0, 100, 0, -1);
        tick();

        run_frame(0, 4, 0, 0, 0, 6);
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        run_frame(0, 4, 0, 0, 0, -1);
        tick();

        for (int k = 0; k < 4; k++) begin
            run_frame(0, 4, 1, 0, 30, -1);
            run_frame(1, 2, 1, 0, 30, -1);
            run_frame(2, 5, 1, 0, 30, -1);
            run_frame(2, 5, 1, 0, 0, -1);
        end
        tick();
        tick();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
